life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parameterised Game-of-Life generation engine. It holds a WIDTH x HEIGHT cell grid and computes each next generation row-serially, one row per clock, into a shadow buffer.
- The whole buffer commits in a single cycle, so the grid visible on the read port is always a complete generation.
- It succeeds the fixed 8x8 row decoder and counter scheme. It adds selectable toroidal or dead-boundary edges, single-step and free-run control, a generation counter, and still-life/extinction detection.
- It sits between the pattern loader and the display scan logic.

Parameters:
- WIDTH, 8, cells per row (>= 3)
- HEIGHT, 8, rows in grid (>= 3); ROW_AW = clog2(HEIGHT) is derived
- GEN_W, 16, generation counter width

Ports:
- ph1  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  write request for one grid row
- load_ready  out  1  high only in IDLE
- load_addr  in  ROW_AW  row to write
- load_data  in  WIDTH  row contents; bit c = column c
- clear  in  1  zero the whole grid (IDLE only)
- step  in  1  single-cycle request to compute one generation
- run  in  1  level; free-running generations while high
- wrap_mode  in  1  1 = toroidal edges, 0 = cells outside the grid are dead
- rd_addr  in  ROW_AW  read row select
- rd_data  out  WIDTH  combinational read of committed grid[rd_addr]
- busy  out  1  high in SWEEP and COMMIT
- gen_done  out  1  one-cycle pulse on the cycle after a commit
- still  out  1  last committed generation equal to its predecessor
- extinct  out  1  last committed generation all zero
- gen_count  out  GEN_W  committed generations since reset/load/clear

Behaviour:
- Reset: grid, shadow buffer and gen_count go to 0. still, extinct, gen_done and busy go to 0. State goes to IDLE and load_ready = 1. Reset during SWEEP/COMMIT abandons the generation, and no gen_done is produced.
- FSM states: IDLE, SWEEP, COMMIT.
- IDLE, priority reset > clear > load > step/run:
  - clear: zeroes the grid and resets gen_count, still and extinct.
  - load_valid: writes grid[load_addr] = load_data and resets gen_count, still and extinct. A step on the same cycle is dropped.
  - step=1 or run=1: latches wrap_mode, sets row index r = 0, goes to SWEEP.
  - load_addr >= HEIGHT: write ignored.
- SWEEP: each edge writes shadow[r] = next-state of row r from committed rows r-1, r, r+1. After r = HEIGHT-1 the FSM goes to COMMIT.
- Row neighbours:
  - wrap=1: indices are taken mod HEIGHT and mod WIDTH.
  - wrap=0: out-of-range rows/columns read as 0.
- Per-cell rule: neighbour sum is 4 bits (0..8, no overflow). Next = (sum==3) | (cell & sum==2).
- COMMIT, single edge:
  - grid <= shadow
  - still <= (shadow == grid)
  - extinct <= (shadow == 0)
  - gen_count <= gen_count + 1, wrapping at 2^GEN_W
  - gen_done asserts on the following cycle for exactly one cycle
- After COMMIT:
  - Goes back to SWEEP (r = 0, wrap_mode re-latched) iff run = 1 and the new still = 0 and the new extinct = 0.
  - Otherwise goes to IDLE; run therefore auto-halts on a static or empty grid.
- Latency: step sampled on edge E0 → grid and gen_count update on edge E0 + HEIGHT + 1 → gen_done high in the cycle after that edge. Back-to-back generations in run mode take HEIGHT + 1 cycles each.
- Ignored while busy: load_valid, clear and step; changes to wrap_mode mid-generation.
- rd_data never shows partial results.

Test Plan:
- Blinker, 8x8, wrap=1. Load row3 = 0x1C, step.
  → edge 9 after step: rows 2, 3, 4 = 0x08, others 0; gen_count = 1; still = 0; gen_done single pulse. Second step restores row3 = 0x1C.
- Block still life. Load rows 1, 2 = 0x06, run = 1 held.
  → exactly one commit; still = 1; busy falls; gen_count stays 1 for 50 further cycles.
- Boundary mode. Load row0 = 0x07, step.
  → wrap=1: rows 7, 0, 1 = 0x02.
  → wrap=0: rows 0, 1 = 0x02, row 7 = 0x00.
- Eight-neighbour case. Load rows 2–4 = 0x1C, step.
  → rows 1..5 = 0x08, 0x14, 0x22, 0x14, 0x08; centre (row 3, bit 3) dead.
- Glider on torus. wrap=1, run=1.
  → after 32 commits the grid equals the initial pattern; gen_count = 32; still never set.
- Reset and handshake.
  → load_valid during SWEEP: no write.
  → reset 3 cycles after step: next cycle busy = 0, gen_count = 0, all rd_data = 0, no gen_done.
  → extinct: a single cell with step gives extinct = 1.

Source files
------------

// File: rtl/life_engine.sv
// Game-of-Life generation engine: row-serial next-state sweep into a shadow
// buffer, then a single-cycle commit so the read port only ever shows whole generations.
//
// state  | meaning
// IDLE   | accepts load/clear, waits for step or run
// SWEEP  | one shadow row per clock, r = 0 .. HEIGHT-1
// COMMIT | shadow -> grid, update still/extinct/gen_count
module life_engine #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int GEN_W  = 16,
   localparam int ROW_AW = $clog2(HEIGHT)
) (
   input  logic              ph1,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ROW_AW-1:0] load_addr,
   input  logic [WIDTH-1:0]  load_data,
   input  logic              clear,
   input  logic              step,
   input  logic              run,
   input  logic              wrap_mode,
   input  logic [ROW_AW-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic              busy,
   output logic              gen_done,
   output logic              still,
   output logic              extinct,
   output logic [GEN_W-1:0]  gen_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SWEEP  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]        state;
   logic [ROW_AW-1:0] r;
   logic              wrap_q;
   logic              run_halted;
   logic [WIDTH-1:0]  grid   [HEIGHT];
   logic [WIDTH-1:0]  shadow [HEIGHT];

   logic [WIDTH-1:0]  row_up, row_mid, row_dn, row_next;
   logic [WIDTH-1:0]  nb [8];
   logic [3:0]        sum;
   logic              still_n, extinct_n;

   // Bit c of the result is the neighbour at column c-1 / c+1 of the source row.
   function automatic logic [WIDTH-1:0] west_of(input logic [WIDTH-1:0] row, input logic w);
      return {row[WIDTH-2:0], w & row[WIDTH-1]};
   endfunction

   function automatic logic [WIDTH-1:0] east_of(input logic [WIDTH-1:0] row, input logic w);
      return {w & row[0], row[WIDTH-1:1]};
   endfunction

   always_comb begin
      row_mid = grid[r];
      row_up  = '0;
      row_dn  = '0;
      if (r != '0)                       row_up = grid[r - ROW_AW'(1)];
      else if (wrap_q)                   row_up = grid[HEIGHT-1];
      if (r != ROW_AW'(HEIGHT-1))        row_dn = grid[r + ROW_AW'(1)];
      else if (wrap_q)                   row_dn = grid[0];

      nb[0] = west_of(row_up, wrap_q);
      nb[1] = row_up;
      nb[2] = east_of(row_up, wrap_q);
      nb[3] = west_of(row_mid, wrap_q);
      nb[4] = east_of(row_mid, wrap_q);
      nb[5] = west_of(row_dn, wrap_q);
      nb[6] = row_dn;
      nb[7] = east_of(row_dn, wrap_q);

      row_next = '0;
      sum      = '0;
      for (int c = 0; c < WIDTH; c++) begin
         sum = '0;
         for (int k = 0; k < 8; k++) sum = sum + {3'b000, nb[k][c]};
         row_next[c] = (sum == 4'd3) | (row_mid[c] & (sum == 4'd2));
      end
   end

   always_comb begin
      still_n   = 1'b1;
      extinct_n = 1'b1;
      for (int i = 0; i < HEIGHT; i++) begin
         if (shadow[i] != grid[i]) still_n   = 1'b0;
         if (shadow[i] != '0)      extinct_n = 1'b0;
      end
   end

   assign load_ready = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign rd_data    = (int'(rd_addr) < HEIGHT) ? grid[rd_addr] : '0;

   always_ff @(posedge ph1) begin
      gen_done <= 1'b0;
      if (reset) begin
         state      <= S_IDLE;
         r          <= '0;
         wrap_q     <= 1'b0;
         run_halted <= 1'b0;
         gen_count  <= '0;
         still      <= 1'b0;
         extinct    <= 1'b0;
         for (int i = 0; i < HEIGHT; i++) begin
            grid[i]   <= '0;
            shadow[i] <= '0;
         end
      end else begin
         // A run that auto-halted stays halted until run drops or the grid is reloaded.
         if (!run) run_halted <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear) begin
                  for (int i = 0; i < HEIGHT; i++) grid[i] <= '0;
                  gen_count  <= '0;
                  still      <= 1'b0;
                  extinct    <= 1'b0;
                  run_halted <= 1'b0;
               end else if (load_valid) begin
                  if (int'(load_addr) < HEIGHT) grid[load_addr] <= load_data;
                  gen_count  <= '0;
                  still      <= 1'b0;
                  extinct    <= 1'b0;
                  run_halted <= 1'b0;
               end else if (step || (run && !run_halted)) begin
                  wrap_q <= wrap_mode;
                  r      <= '0;
                  state  <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               shadow[r] <= row_next;
               if (r == ROW_AW'(HEIGHT-1)) state <= S_COMMIT;
               else                        r     <= r + ROW_AW'(1);
            end
            S_COMMIT: begin
               for (int i = 0; i < HEIGHT; i++) grid[i] <= shadow[i];
               still     <= still_n;
               extinct   <= extinct_n;
               gen_count <= gen_count + GEN_W'(1);
               gen_done  <= 1'b1;
               if (run && !still_n && !extinct_n) begin
                  wrap_q <= wrap_mode;
                  r      <= '0;
                  state  <= S_SWEEP;
               end else begin
                  run_halted <= run;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: stimulus queues expected generations and
// snapshots, a monitor compares them when gen_done pulses or a snapshot is requested.
`timescale 1ns/100ps
module tb_life_engine;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int GW = 16;
   localparam int AW = 3;

   logic          ph1 = 1'b0;
   logic          reset = 1'b1;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [AW-1:0] load_addr = '0;
   logic [W-1:0]  load_data = '0;
   logic          clear = 1'b0;
   logic          step = 1'b0;
   logic          run = 1'b0;
   logic          wrap_mode = 1'b1;
   logic [AW-1:0] rd_addr = '0;
   logic [W-1:0]  rd_data;
   logic          busy, gen_done, still, extinct;
   logic [GW-1:0] gen_count;

   always #5 ph1 = ~ph1;

   life_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
      .ph1(ph1), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data), .clear(clear), .step(step),
      .run(run), .wrap_mode(wrap_mode), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .gen_done(gen_done), .still(still), .extinct(extinct),
      .gen_count(gen_count)
   );

   typedef struct {
      bit          chk_grid;
      logic [63:0] g;
      logic [15:0] cnt;
      bit          st;
      bit          ex;
      bit          bz;
      int          cyc;
   } exp_t;

   exp_t gen_q[$];
   exp_t snap_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   snap_req = 1'b0;

   always @(posedge ph1) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: reads the whole committed grid within the low half of the clock.
   initial begin
      bit          prev_gd;
      logic [63:0] g;
      exp_t        e;
      prev_gd = 1'b0;
      forever begin
         @(negedge ph1);
         if (gen_done || snap_req) begin
            for (int i = 0; i < H; i++) begin
               rd_addr = AW'(i);
               #0.5;
               g[8*i +: 8] = rd_data;
            end
         end
         if (gen_done) begin
            check("gen_done_single_pulse", 64'(prev_gd), 64'd0);
            check("gen_done_expected", 64'(gen_q.size() != 0), 64'd1);
            if (gen_q.size() != 0) begin
               e = gen_q.pop_front();
               if (e.chk_grid) check("gen_grid", g, e.g);
               check("gen_count", 64'(gen_count), 64'(e.cnt));
               check("gen_still", 64'(still), 64'(e.st));
               check("gen_extinct", 64'(extinct), 64'(e.ex));
               if (e.cyc != 0) check("gen_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (snap_req) begin
            check("snap_expected", 64'(snap_q.size() != 0), 64'd1);
            if (snap_q.size() != 0) begin
               e = snap_q.pop_front();
               check("snap_grid", g, e.g);
               check("snap_count", 64'(gen_count), 64'(e.cnt));
               check("snap_still", 64'(still), 64'(e.st));
               check("snap_extinct", 64'(extinct), 64'(e.ex));
               check("snap_busy", 64'(busy), 64'(e.bz));
               check("snap_load_ready", 64'(load_ready), 64'(!e.bz));
            end
         end
         prev_gd = gen_done;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge ph1);
      #1;
   endtask

   task automatic load_row(input int a, input logic [7:0] d);
      load_valid = 1'b1; load_addr = AW'(a); load_data = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic push_gen(input logic [63:0] g, input int cnt, input bit st, input bit ex,
                           input int cy, input bit cg = 1'b1);
      exp_t e;
      e.chk_grid = cg; e.g = g; e.cnt = 16'(cnt); e.st = st; e.ex = ex; e.bz = 1'b0; e.cyc = cy;
      gen_q.push_back(e);
   endtask

   task automatic snap(input logic [63:0] g, input int cnt, input bit st, input bit ex, input bit bz);
      exp_t e;
      e.chk_grid = 1'b1; e.g = g; e.cnt = 16'(cnt); e.st = st; e.ex = ex; e.bz = bz; e.cyc = 0;
      snap_q.push_back(e);
      snap_req = 1'b1; tick(); snap_req = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin tick(); n++; end
      check("idle_within_bound", 64'(busy), 64'd0);
   endtask

   // Expect one generation from a single step issued now.
   task automatic step_gen(input logic [63:0] g, input int cnt, input bit st, input bit ex);
      push_gen(g, cnt, st, ex, cyc + H + 2);
      step = 1'b1; tick(); step = 1'b0;
      wait_idle(40);
      tick(2);
   endtask

   initial begin
      int n;
      tick(2);
      reset = 1'b0;
      tick();
      snap(64'h0, 0, 0, 0, 0);

      // blinker, torus
      load_row(3, 8'h1C);
      step_gen(64'h00000008_08080000, 1, 0, 0);
      step_gen(64'h00000000_1C000000, 2, 0, 0);
      do_clear();
      snap(64'h0, 0, 0, 0, 0);

      // block with run held: one commit then auto-halt
      load_row(1, 8'h06);
      load_row(2, 8'h06);
      push_gen(64'h00000000_00060600, 1, 1, 0, cyc + H + 2);
      run = 1'b1;
      tick(60);
      snap(64'h00000000_00060600, 1, 1, 0, 0);
      run = 1'b0;
      tick(2);

      // row edge, torus then dead boundary
      do_clear(); wrap_mode = 1'b1; load_row(0, 8'h07);
      step_gen(64'h02000000_00000202, 1, 0, 0);
      do_clear(); wrap_mode = 1'b0; load_row(0, 8'h07);
      step_gen(64'h00000000_00000202, 1, 0, 0);

      // column edge, torus then dead boundary
      do_clear(); wrap_mode = 1'b1; load_row(4, 8'h83);
      step_gen(64'h00000101_01000000, 1, 0, 0);
      do_clear(); wrap_mode = 1'b0; load_row(4, 8'h83);
      step_gen(64'h0, 1, 0, 1);

      // 3x3 block: every neighbour count exercised, centre dies
      do_clear(); wrap_mode = 1'b1;
      load_row(2, 8'h1C); load_row(3, 8'h1C); load_row(4, 8'h1C);
      step_gen(64'h00000814_22140800, 1, 0, 0);

      // glider on torus returns home after 32 generations
      do_clear(); wrap_mode = 1'b1;
      load_row(0, 8'h02); load_row(1, 8'h04); load_row(2, 8'h07);
      for (int k = 1; k < 32; k++) push_gen(64'h0, k, 0, 0, 0, 1'b0);
      push_gen(64'h00000000_00070402, 32, 0, 0, 0);
      run = 1'b1;
      n = 0;
      for (int t = 0; t < 1000 && n < 31; t++) begin
         @(negedge ph1);
         if (gen_done) n++;
      end
      run = 1'b0;
      check("glider_gens_before_stop", 64'(n), 64'd31);
      tick();
      wait_idle(40);
      tick(2);

      // load/clear/step while busy are ignored
      do_clear(); wrap_mode = 1'b1; load_row(3, 8'h1C);
      push_gen(64'h00000008_08080000, 1, 0, 0, cyc + H + 2);
      step = 1'b1; tick(); step = 1'b0;
      load_valid = 1'b1; load_addr = '0; load_data = 8'hFF; clear = 1'b1; step = 1'b1; wrap_mode = 1'b0;
      tick();
      load_valid = 1'b0; clear = 1'b0; step = 1'b0;
      snap(64'h00000000_1C000000, 0, 0, 0, 1);
      wrap_mode = 1'b1;
      wait_idle(40);
      tick(2);

      // reset mid-sweep abandons the generation
      do_clear(); load_row(3, 8'h1C);
      step = 1'b1; tick(); step = 1'b0;
      tick(2);
      reset = 1'b1; tick(); reset = 1'b0;
      snap(64'h0, 0, 0, 0, 0);
      tick(20);

      // single cell dies out
      load_row(5, 8'h10);
      step_gen(64'h0, 1, 0, 1);

      tick(5);
      check("scoreboard_drained", 64'(gen_q.size() + snap_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
